// File: rtl/clint_pkg.sv
// Shared definitions for the multi-hart CLINT: register offsets, access FSM
// states and the byte-lane merge used for the 64-bit timer registers.
package clint_pkg;

  localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Merge a 32-bit bus write into the low or high half of a 64-bit register.
  function automatic logic [63:0] half_write(input logic [63:0] old, input logic hi,
                                             input logic [31:0] wd, input logic [3:0] mask);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[(hi ? 32 : 0) + 8 * b +: 8] = wd[8 * b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: emits a one-cycle tick every div cycles (every cycle when
// div is 0 or 1); a reduced div takes effect at the very next comparison.
module clint_prescaler
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W+1:0] r_count;
  logic [DIV_W+1:0] w_limit;

  assign w_limit = (div == '0) ? '0 : (DIV_W + 2)'(div) - (DIV_W + 2)'(1);
  assign tick    = (r_count >= w_limit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_count <= '0;
    else if (tick) r_count <= '0;
    else r_count <= r_count + (DIV_W + 2)'(1);
  end

endmodule

// File: rtl/clint_multihart.sv
// Core-local interruptor for NHARTS harts: msip and mtimecmp per hart plus a
// shared prescaled mtime, behind a simple valid/ready register port.
module clint_multihart
  import clint_pkg::*;
#(
  parameter int          NHARTS  = 2,
  parameter int          MTIME_W = 64,
  parameter int          DIV_W   = 16,
  parameter logic [31:0] BASE    = 32'h1100_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [31:0]       addr,
  input  logic [3:0]        wmask,
  input  logic [31:0]       wdata,
  input  logic [DIV_W-1:0]  div,
  output logic [31:0]       rdata,
  output logic              is_valid,
  output logic              ready,
  output logic [NHARTS-1:0] msip_irq,
  output logic [NHARTS-1:0] mtip_irq,
  output state_t            dbg_state
);

  localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  // Handshake: a request is taken in IDLE when valid hits a decoded register;
  // ready pulses for exactly one cycle after, and RESP ignores valid entirely.
  logic [31:0]        w_msip_off, w_cmp_off, w_off, w_rd;
  logic               w_sel_msip, w_sel_cmp, w_sel_mtime, w_hi, w_acc, w_wr, w_tick;
  logic [HW-1:0]      w_msip_hart, w_cmp_hart;
  logic [MTIME_W-1:0] w_cmp [NHARTS];
  logic [NHARTS-1:0]  w_msip;
  logic [63:0]        w_cmp64, w_mtime64;

  state_t             r_state;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [MTIME_W-1:0] r_mtime;

  assign w_off       = addr - BASE;
  assign w_msip_off  = w_off - MSIP_OFF;
  assign w_cmp_off   = w_off - MTIMECMP_OFF;
  assign w_sel_msip  = (w_msip_off < 32'(4 * NHARTS)) && (w_off[1:0] == 2'b00);
  assign w_sel_cmp   = (w_cmp_off < 32'(8 * NHARTS)) && (w_off[1:0] == 2'b00);
  assign w_sel_mtime = (w_off == MTIME_OFF) || (w_off == MTIME_OFF + 32'd4);
  assign w_msip_hart = HW'(w_msip_off >> 2);
  assign w_cmp_hart  = HW'(w_cmp_off >> 3);
  assign w_hi        = w_off[2];

  assign is_valid = valid && (w_sel_msip || w_sel_cmp || w_sel_mtime);
  assign w_acc    = (r_state == ST_IDLE) && is_valid;
  assign w_wr     = w_acc && (wmask != 4'b0000);

  clint_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .div    (div),
    .tick   (w_tick)
  );

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    logic               r_msip, r_mtip;
    logic [MTIME_W-1:0] r_cmp;
    logic               w_hit_msip, w_hit_cmp;

    assign w_hit_msip = w_wr && w_sel_msip && (w_msip_hart == HW'(h));
    assign w_hit_cmp  = w_wr && w_sel_cmp && (w_cmp_hart == HW'(h));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_msip <= 1'b0;
        r_cmp  <= '1;
        r_mtip <= 1'b0;
      end else begin
        r_mtip <= (r_mtime >= r_cmp);
        if (w_hit_msip && wmask[0]) r_msip <= wdata[0];
        if (w_hit_cmp) r_cmp <= MTIME_W'(half_write(64'(r_cmp), w_hi, wdata, wmask));
      end
    end

    assign w_cmp[h]    = r_cmp;
    assign w_msip[h]   = r_msip;
    assign mtip_irq[h] = r_mtip;
  end

  assign msip_irq  = w_msip;
  assign w_cmp64   = 64'(w_cmp[w_cmp_hart]);
  assign w_mtime64 = 64'(r_mtime);

  always_comb begin
    w_rd = '0;
    if (w_sel_msip)       w_rd = {31'b0, w_msip[w_msip_hart]};
    else if (w_sel_cmp)   w_rd = w_hi ? w_cmp64[63:32] : w_cmp64[31:0];
    else if (w_sel_mtime) w_rd = w_hi ? w_mtime64[63:32] : w_mtime64[31:0];
  end

  // A software write to mtime takes priority over the prescaler increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_mtime <= '0;
    else if (w_wr && w_sel_mtime) r_mtime <= MTIME_W'(half_write(w_mtime64, w_hi, wdata, wmask));
    else if (w_tick) r_mtime <= r_mtime + MTIME_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (is_valid) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
            r_rdata <= (wmask == 4'b0000) ? w_rd : '0;
          end else begin
            r_ready <= 1'b0;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clint_multihart.sv
// Bench for clint_multihart: a register-level model of the CLINT checked
// every cycle, plus directed accesses with hand-computed expectations.
module tb_clint_multihart;
  import clint_pkg::*;

  localparam int          NH   = 2;
  localparam int          DW   = 16;
  localparam logic [31:0] BASE = 32'h1100_0000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          valid = 1'b0;
  logic [31:0]   addr = '0;
  logic [3:0]    wmask = '0;
  logic [31:0]   wdata = '0;
  logic [DW-1:0] div = '0;
  logic [31:0]   rdata;
  logic          is_valid, ready;
  logic [NH-1:0] msip_irq, mtip_irq;
  state_t        dbg_state;

  always #5 clk = ~clk;

  clint_multihart #(.NHARTS(NH), .MTIME_W(64), .DIV_W(DW), .BASE(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .addr      (addr),
    .wmask     (wmask),
    .wdata     (wdata),
    .div       (div),
    .rdata     (rdata),
    .is_valid  (is_valid),
    .ready     (ready),
    .msip_irq  (msip_irq),
    .mtip_irq  (mtip_irq),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_mtip;
  int            m_since_tick;
  bit            m_resp_cycle;
  logic [31:0]   exp_q[$];

  function automatic int decode(input logic [31:0] a, output int idx, output bit hi);
    logic [31:0] off;
    off = a - BASE;
    idx = 0;
    hi  = 0;
    if ((off % 4) != 0) return 0;
    if (off < 4 * NH) begin
      idx = int'(off / 4);
      return 1;
    end
    if (off >= 32'h4000 && off < 32'h4000 + 8 * NH) begin
      idx = int'((off - 32'h4000) / 8);
      hi  = ((off % 8) == 4);
      return 2;
    end
    if (off == 32'hBFF8 || off == 32'hBFFC) begin
      hi = (off == 32'hBFFC);
      return 3;
    end
    return 0;
  endfunction

  function automatic logic [63:0] lanes(input logic [63:0] old, input bit hi,
                                        input logic [31:0] wd, input logic [3:0] m);
    logic [63:0] bm;
    bm = '0;
    for (int b = 0; b < 4; b++) if (m[b]) bm[8 * b +: 8] = 8'hFF;
    if (hi) bm = bm << 32;
    return (old & ~bm) | ({wd, wd} & bm);
  endfunction

  int          mk, mi;
  bit          mh, m_tick, m_twr;
  logic [31:0] m_rd;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mtime = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_msip = '0;
      m_mtip = '0;
      m_since_tick = 0;
      m_resp_cycle = 0;
      exp_q.delete();
    end else begin
      m_tick = (m_since_tick + 1 >= ((div <= 1) ? 1 : int'(div)));
      m_since_tick = m_tick ? 0 : m_since_tick + 1;
      for (int h = 0; h < NH; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
      mk = decode(addr, mi, mh);
      m_twr = 0;
      if (valid && mk != 0 && !m_resp_cycle) begin
        m_resp_cycle = 1;
        case (mk)
          1: m_rd = {31'b0, m_msip[mi]};
          2: m_rd = mh ? m_cmp[mi][63:32] : m_cmp[mi][31:0];
          default: m_rd = mh ? m_mtime[63:32] : m_mtime[31:0];
        endcase
        exp_q.push_back((wmask == 4'b0000) ? m_rd : 32'h0);
        if (wmask != 4'b0000) begin
          case (mk)
            1: if (wmask[0]) m_msip[mi] = wdata[0];
            2: m_cmp[mi] = lanes(m_cmp[mi], mh, wdata, wmask);
            default: begin
              m_mtime = lanes(m_mtime, mh, wdata, wmask);
              m_twr = 1;
            end
          endcase
        end
      end else begin
        m_resp_cycle = 0;
      end
      if (m_tick && !m_twr) m_mtime = m_mtime + 64'd1;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  int  ck, ci;
  bit  ch;
  always @(posedge clk) begin
    #1;
    ck = decode(addr, ci, ch);
    check("is_valid", is_valid, valid && (ck != 0));
    check("ready", ready, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      if (ready) check("rdata", rdata, exp_q[0]);
      void'(exp_q.pop_front());
    end
    check("msip_irq", msip_irq, m_msip);
    check("mtip_irq", mtip_irq, m_mtip);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     output logic [31:0] q);
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wmask = m;
    wdata = d;
    @(negedge clk);
    valid = 1'b0;
    wmask = '0;
    check("bus_ready", ready, 1);
    check("bus_state", dbg_state, ST_RESP);
    q = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] q;
  initial begin
    resetn = 1'b0;
    div    = 16'd4;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_msip", msip_irq, 0);
    check("rst_mtip", mtip_irq, 0);
    check("rst_state", dbg_state, ST_IDLE);
    resetn = 1'b1;

    // div=4: reads 4 cycles apart see 0, 1, 2
    bus(BASE + 32'hBFF8, 4'h0, 0, q); check("mtime_r0", q, 32'd0);
    idle(2);
    bus(BASE + 32'hBFF8, 4'h0, 0, q); check("mtime_r1", q, 32'd1);
    idle(2);
    bus(BASE + 32'hBFF8, 4'h0, 0, q); check("mtime_r2", q, 32'd2);
    bus(BASE + 32'hBFFC, 4'h0, 0, q); check("mtime_hi0", q, 32'd0);

    // msip for hart 1
    bus(BASE + 32'h4, 4'hF, 32'h1, q); check("msip_set", msip_irq, 2'b10);
    bus(BASE + 32'h4, 4'h0, 0, q);     check("msip_read", q, 32'h1);
    bus(BASE + 32'h4, 4'hF, 32'h0, q); check("msip_clr", msip_irq, 2'b00);

    // valid held five cycles
    @(negedge clk);
    valid = 1'b1;
    addr  = BASE + 32'h4;
    wmask = 4'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("held_ready_c%0d", i + 1), ready, (i % 2) == 1);
      @(negedge clk);
    end
    valid = 1'b0;
    idle(2);

    // undecoded address
    @(negedge clk);
    valid = 1'b1;
    addr  = BASE + 32'h8;
    #1 check("undec_is_valid", is_valid, 0);
    @(negedge clk); check("undec_ready_a", ready, 0);
    @(negedge clk); check("undec_ready_b", ready, 0);
    valid = 1'b0;

    // mtimecmp[1]=0x10 while mtime=0x0E, div=1
    div = 16'd1;
    bus(BASE + 32'h400C, 4'hF, 32'h0, q);
    bus(BASE + 32'hBFF8, 4'hF, 32'h0000_000D, q);
    bus(BASE + 32'h4008, 4'hF, 32'h0000_0010, q);
    check("mtip_c1", mtip_irq, 2'b00);
    @(negedge clk); check("mtip_c2", mtip_irq, 2'b00);
    @(negedge clk); check("mtip_c3", mtip_irq, 2'b10);

    // wrap from all-ones
    bus(BASE + 32'hBFFC, 4'hF, 32'hFFFF_FFFF, q);
    bus(BASE + 32'hBFF8, 4'hF, 32'hFFFF_FFFE, q);
    check("wrap_mtip_a", mtip_irq, 2'b10);
    @(negedge clk); check("wrap_mtip_b", mtip_irq, 2'b10);
    @(negedge clk); check("wrap_mtip_c", mtip_irq, 2'b11);
    @(negedge clk); check("wrap_mtip_d", mtip_irq, 2'b00);
    bus(BASE + 32'hBFFC, 4'h0, 0, q); check("wrap_hi", q, 32'h0);

    // byte write landing in a tick cycle at all-ones
    bus(BASE + 32'hBFFC, 4'hF, 32'hFFFF_FFFF, q);
    bus(BASE + 32'hBFF8, 4'hF, 32'hFFFF_FFFE, q);
    bus(BASE + 32'hBFF8, 4'b0001, 32'h0000_00AA, q);
    bus(BASE + 32'hBFF8, 4'h0, 0, q); check("bytewr_lo", q, 32'hFFFF_FFAB);
    bus(BASE + 32'hBFFC, 4'h0, 0, q); check("bytewr_hi", q, 32'hFFFF_FFFF);

    // reset asserted during an mtimecmp write
    div = 16'd4;
    @(negedge clk);
    valid = 1'b1;
    addr  = BASE + 32'h4000;
    wmask = 4'hF;
    wdata = 32'h0000_1234;
    #3;
    resetn = 1'b0;
    valid  = 1'b0;
    wmask  = 4'h0;
    @(negedge clk); check("rstmid_ready_a", ready, 0);
    @(negedge clk); check("rstmid_ready_b", ready, 0);
    resetn = 1'b1;
    @(negedge clk); check("rstmid_ready_c", ready, 0);
    @(negedge clk); check("rstmid_ready_d", ready, 0);
    bus(BASE + 32'h4000, 4'h0, 0, q); check("rstmid_cmp0_lo", q, 32'hFFFF_FFFF);
    bus(BASE + 32'h4004, 4'h0, 0, q); check("rstmid_cmp0_hi", q, 32'hFFFF_FFFF);
    bus(BASE + 32'h400C, 4'h0, 0, q); check("rstmid_cmp1_hi", q, 32'hFFFF_FFFF);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
